// File: rtl/wide_adder_ctrl_if.sv
// Handshake/bus bundle between the multi-precision add sequencer and its requester.
interface wide_adder_ctrl_if #(
  parameter int NUM_WORDS = 4
);
  localparam int W = 16 * NUM_WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );
endinterface

// File: rtl/wide_adder_ctrl.sv
// Word-serial multi-precision adder: one shared 16-bit adder, LS word first,
// carry registered between words, full result published with a done pulse.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
endmodule

module wide_adder_ctrl #(
  parameter int NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  wide_adder_ctrl_if.slave  bus
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic [IW-1:0]                r_idx;
  logic                         r_carry;
  logic [NUM_WORDS-1:0][15:0]   r_a, r_b, r_work, r_sum;
  logic                         r_ovf;

  logic                         w_accept, w_last;
  logic [15:0]                  w_word_sum;
  logic                         w_word_co;
  logic [NUM_WORDS-1:0][15:0]   w_work_next;

  adder_16bit u_add (
    .a        (r_a[r_idx]),
    .b        (r_b[r_idx]),
    .carry_in (r_carry),
    .sum      (w_word_sum),
    .overflow (w_word_co)
  );

  assign w_last = (r_idx == LAST);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: begin
        w_next = S_IDLE;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Work register with the current word merged in, so the last word lands in sum directly.
  always_comb begin
    w_work_next        = r_work;
    w_work_next[r_idx] = w_word_sum;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.carry_in;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_word_co;
      if (w_last) begin
        r_sum <= w_work_next;
        r_ovf <= w_word_co;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_wide_adder_ctrl.sv
// Bench for wide_adder_ctrl: directed vector table, corner sequences, random vs. arithmetic model.
module tb_wide_adder_ctrl;
  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  wide_adder_ctrl_if #(.NUM_WORDS(NW)) bus ();

  wide_adder_ctrl #(.NUM_WORDS(NW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: exact (W+1)-bit integer sum.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Protocol invariants checked every cycle outside reset.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      chk("busy_done_excl", {{W{1'b0}}, bus.busy & bus.done}, '0);
      chk("done_single", {{W{1'b0}}, bus.done & prev_done}, '0);
      prev_done <= bus.done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Issue one op, scramble inputs after acceptance, check busy window and done latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input string nm, output logic [W-1:0] s, output logic o);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.carry_in = cin;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.carry_in = 1'($urandom);
    for (int i = 0; i < NW; i++) begin
      chk({nm, "_busy"}, {{W{1'b0}}, bus.busy}, 1);
      chk({nm, "_nodone"}, {{W{1'b0}}, bus.done}, 0);
      @(posedge clk); #1;
    end
    chk({nm, "_done"}, {{W{1'b0}}, bus.done}, 1);
    chk({nm, "_idle"}, {{W{1'b0}}, bus.busy}, 0);
    s = bus.sum;
    o = bus.overflow;
    @(posedge clk); #1;
    chk({nm, "_done_drop"}, {{W{1'b0}}, bus.done}, 0);
  endtask

  logic [W-1:0] s, ra, rb;
  logic         o, rc;
  logic [W:0]   m;
  int           seen_done;

  initial begin
    vecs.push_back('{"ripple16",  64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0});
    vecs.push_back('{"full_cin",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 64'h0,                   1'b1});
    vecs.push_back('{"top_ovf",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, 1'b1});
    vecs.push_back('{"small",     64'd3,                   64'd4,                   1'b0, 64'd7,                   1'b0});
    vecs.push_back('{"all_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"mid_chain", 64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 64'h0001_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"zero",      64'h0,                   64'h0,                   1'b0, 64'h0,                   1'b0});

    // Reset held with start asserted: nothing accepted.
    n_rst = 1'b0; bus.start = 1'b1;
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1; bus.carry_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {{W{1'b0}}, bus.busy}, 0);
    chk("rst_done", {{W{1'b0}}, bus.done}, 0);
    chk("rst_sum",  {1'b0, bus.sum}, 0);
    chk("rst_ovf",  {{W{1'b0}}, bus.overflow}, 0);
    bus.start = 1'b0; n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_busy", {{W{1'b0}}, bus.busy}, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].name, s, o);
      chk({vecs[i].name, "_sum"}, {1'b0, s}, {1'b0, vecs[i].exp_sum});
      chk({vecs[i].name, "_ovf"}, {{W{1'b0}}, o}, {{W{1'b0}}, vecs[i].exp_ovf});
    end

    // Start in RUN ignored, then back-to-back accept from DONE.
    bus.start = 1'b1; bus.a = 64'd3; bus.b = 64'd4; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 64'd9; bus.b = 64'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("ign_done", {{W{1'b0}}, bus.done}, 1);
    chk("ign_sum",  {1'b0, bus.sum}, 65'd7);
    bus.start = 1'b1; bus.a = 64'd9; bus.b = 64'd9; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("b2b_busy", {{W{1'b0}}, bus.busy}, 1);
      @(posedge clk); #1;
    end
    chk("b2b_done", {{W{1'b0}}, bus.done}, 1);
    chk("b2b_sum",  {1'b0, bus.sum}, 65'd18);
    @(posedge clk); #1;

    // Reset during the second RUN cycle aborts and clears the held result.
    bus.start = 1'b1; bus.a = 64'd5; bus.b = 64'd6; bus.carry_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("abort_busy", {{W{1'b0}}, bus.busy}, 0);
    chk("abort_sum",  {1'b0, bus.sum}, 0);
    chk("abort_ovf",  {{W{1'b0}}, bus.overflow}, 0);
    seen_done = 0;
    repeat (NW + 2) begin
      if (bus.done === 1'b1) seen_done++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 65'(seen_done), 0);
    do_op(64'd1, 64'd1, 1'b0, "post_abort", s, o);
    chk("post_abort_sum", {1'b0, s}, 65'd2);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ~ra;
        2: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        default: rb = {48'hFFFF_FFFF_FFFF, rb[15:0]};
      endcase
      m = model(ra, rb, rc);
      do_op(ra, rb, rc, "rand", s, o);
      chk("rand_sum", {1'b0, s}, {1'b0, m[W-1:0]});
      chk("rand_ovf", {{W{1'b0}}, o}, {{W{1'b0}}, m[W]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
